window_scan_ctrl: RTL

Sequencer that walks a sliding WIN×WIN window over a square feature-map tile and emits one (ptr, ptc, pt_bias) tap coordinate per handshake to the window address unit. It sits between the layer controller, which issues start and reads done, and the address unit that turns coordinates into DDR3 word addresses. It marks the first tap of every window so the address unit reloads its base address.

---
 rtl/window_scan_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/window_scan_ctrl.sv
// Sliding-window tap sequencer: walks WIN x WIN windows over a square tile and
// hands one (ptr, ptc, pt_bias) coordinate per ready/valid handshake to the address unit.
module window_scan_ctrl #(
   parameter int WIN    = 3,
   parameter int STRIDE = 1,
   parameter int PW     = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [PW-1:0] img_edge,
   input  logic          out_ready,
   output logic          pt_valid,
   output logic [PW-1:0] ptr,
   output logic [PW-1:0] ptc,
   output logic [3:0]    pt_bias,
   output logic          first_tap,
   output logic          last_tap,
   output logic          last_win,
   output logic          busy,
   output logic          done
);

   localparam int          XW        = PW + 2;
   localparam logic [3:0]  LAST_BIAS = 4'(WIN*WIN - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [PW-1:0] edge_q;

   // Extra headroom bits so origin+STRIDE+WIN-1 never wraps at img_edge = 2^PW-1.
   logic [XW-1:0] ptc_nxt, ptr_nxt, edge_x;
   logic          col_wrap, row_end, accept;

   assign edge_x   = XW'(edge_q);
   assign ptc_nxt  = XW'(ptc) + XW'(STRIDE);
   assign ptr_nxt  = XW'(ptr) + XW'(STRIDE);
   assign col_wrap = (ptc_nxt + XW'(WIN-1)) > edge_x;
   assign row_end  = (ptr_nxt + XW'(WIN-1)) > edge_x;
   assign accept   = pt_valid & out_ready;

   assign first_tap = pt_valid && (pt_bias == 4'd0);
   assign last_tap  = pt_valid && (pt_bias == LAST_BIAS);
   assign last_win  = pt_valid && row_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         edge_q   <= '0;
         ptr      <= '0;
         ptc      <= '0;
         pt_bias  <= '0;
         pt_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  edge_q  <= img_edge;
                  ptr     <= '0;
                  ptc     <= '0;
                  pt_bias <= '0;
                  busy    <= 1'b1;
                  if (img_edge >= PW'(WIN-1)) begin
                     state    <= RUN;
                     pt_valid <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  if (pt_bias != LAST_BIAS) begin
                     pt_bias <= pt_bias + 4'd1;
                  end else begin
                     pt_bias <= '0;
                     if (!col_wrap) begin
                        ptc <= ptc_nxt[PW-1:0];
                     end else begin
                        ptc <= '0;
                        if (!row_end) begin
                           ptr <= ptr_nxt[PW-1:0];
                        end else begin
                           ptr      <= '0;
                           pt_valid <= 1'b0;
                           done     <= 1'b1;
                           state    <= DONE;
                        end
                     end
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
